// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the decoder/controller slice.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0]  OPC_HALT  = 7'd93;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decoder/execute handshake.
interface fetch_unit_if #(
   parameter int XLEN = 32
);

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic [XLEN-1:0] instr;
   logic            instr_valid;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus4;
   logic            instr_ready;
   logic            halt;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            halted;
   logic            fetch_err;
   logic [31:0]     instret;

   modport master (
      output imem_req, imem_addr,
      input  imem_rvalid, imem_rdata,
      output instr, instr_valid, pc_out, pc_plus4,
      input  instr_ready, halt, redirect_valid, redirect_pc,
      output halted, fetch_err, instret
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rvalid, imem_rdata,
      input  instr, instr_valid, pc_out, pc_plus4,
      output instr_ready, halt, redirect_valid, redirect_pc,
      input  halted, fetch_err, instret
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for the decoder until execute consumes it.
//
//   state  | meaning
//   FETCH  | imem_req high for one cycle at pc, timeout count cleared
//   WAIT   | waiting for imem_rvalid, counting toward TIMEOUT
//   HOLD   | instr valid to decoder until the instr_ready handshake
//   HALTED | stopped by halt or memory timeout; only rst exits
module fetch_unit #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 255
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   import riscv_pkg::*;

   localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] instr_q;
   logic            halted_q;
   logic            fetch_err_q;
   logic [31:0]     instret_q;
   logic [15:0]     tmo_q;

   // Redirect targets are forced to word alignment.
   always_comb begin
      pc_d = pc_q + PC_STEP;
      if (bus.redirect_valid) begin
         pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= XLEN'(NOP_INSTR);
         halted_q    <= 1'b0;
         fetch_err_q <= 1'b0;
         instret_q   <= '0;
         tmo_q       <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  instr_q <= bus.imem_rdata;
                  state_q <= HOLD;
               end else if (tmo_q == TMO_LAST) begin
                  fetch_err_q <= 1'b1;
                  state_q     <= HALTED;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  if (bus.halt) begin
                     halted_q <= 1'b1;
                     state_q  <= HALTED;
                  end else begin
                     pc_q      <= pc_d;
                     instret_q <= instret_q + 32'd1;
                     state_q   <= FETCH;
                  end
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

   // The request is masked in the rst cycle itself, whatever state was left over.
   assign bus.imem_req    = (state_q == FETCH) && !rst;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state_q == HOLD);
   assign bus.pc_out      = pc_q;
   assign bus.pc_plus4    = pc_q + PC_STEP;
   assign bus.halted      = halted_q;
   assign bus.fetch_err   = fetch_err_q;
   assign bus.instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected fetch addresses are queued by the
// stimulus and popped by a monitor on every imem_req; flags are checked inline.
module tb_fetch_unit;

   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_w;

   fetch_unit_if #(.XLEN(32)) ifa ();
   fetch_unit_if #(.XLEN(32)) ifw ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa.master)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) dut_w (
      .clk (clk),
      .rst (rst_w),
      .bus (ifw.master)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_a[$];
   logic [31:0] exp_w[$];

   logic        mute_a = 1'b0;
   logic        spur_a = 1'b0;
   logic        pend_a = 1'b0;
   logic [31:0] paddr_a = '0;
   logic        pend_w = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0050_0093;
         32'h0000_0004: mem_word = 32'h0000_0013;
         32'h0000_0008: mem_word = 32'h0000_005D;
         32'h0000_0010: mem_word = 32'h0000_0463;
         32'h0000_0100: mem_word = 32'h1234_5013;
         default:       mem_word = NOP_INSTR;
      endcase
   endfunction

   // Memory for dut_a: answers one cycle after each request unless muted.
   initial begin
      ifa.imem_rvalid = 1'b0;
      ifa.imem_rdata  = '0;
      forever begin
         @(negedge clk);
         ifa.imem_rvalid = pend_a | spur_a;
         ifa.imem_rdata  = spur_a ? 32'hDEAD_BEEF : mem_word(paddr_a);
         pend_a  = ifa.imem_req & ~mute_a;
         paddr_a = ifa.imem_addr;
      end
   end

   initial begin
      ifw.imem_rvalid = 1'b0;
      ifw.imem_rdata  = '0;
      forever begin
         @(negedge clk);
         ifw.imem_rvalid = pend_w;
         ifw.imem_rdata  = NOP_INSTR;
         pend_w = ifw.imem_req;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ifa.imem_req === 1'b1) begin
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_req actual=%h required=none", ifa.imem_addr);
            end else begin
               chk("a_imem_addr", ifa.imem_addr, exp_a.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ifw.imem_req === 1'b1) begin
            if (exp_w.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL w_unexpected_req actual=%h required=none", ifw.imem_addr);
            end else begin
               chk("w_imem_addr", ifw.imem_addr, exp_w.pop_front());
            end
         end
      end
   end

   // One HOLD handshake on dut_a; halt/redirect are waved during stall cycles to
   // show they are ignored without instr_ready.
   task automatic hs(input logic [31:0] epc, input logic [31:0] einstr, input logic h,
                     input logic rv, input logic [31:0] rpc, input int stall);
      int n = 0;
      while (ifa.instr_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (ifa.instr_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL hs_wait_valid actual=%b required=1 pc=%h", ifa.instr_valid, epc);
         return;
      end
      chk("hs_pc_out", ifa.pc_out, epc);
      chk("hs_instr", ifa.instr, einstr);
      chk("hs_pc_plus4", ifa.pc_plus4, epc + 32'd4);
      if (stall > 0) begin
         ifa.halt           = 1'b1;
         ifa.redirect_valid = 1'b1;
         ifa.redirect_pc    = 32'h0000_FFF0;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", ifa.instr_valid, 32'd1);
         chk("stall_instr", ifa.instr, einstr);
         chk("stall_pc_out", ifa.pc_out, epc);
         chk("stall_req", ifa.imem_req, 32'd0);
      end
      ifa.instr_ready    = 1'b1;
      ifa.halt           = h;
      ifa.redirect_valid = rv;
      ifa.redirect_pc    = rpc;
      @(posedge clk);
      #1;
      ifa.instr_ready    = 1'b0;
      ifa.halt           = 1'b0;
      ifa.redirect_valid = 1'b0;
      ifa.redirect_pc    = '0;
   endtask

   initial begin
      ifa.instr_ready = 1'b0; ifa.halt = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0;
      ifw.instr_ready = 1'b0; ifw.halt = 1'b0; ifw.redirect_valid = 1'b0; ifw.redirect_pc = '0;
      rst_a = 1'b1;
      rst_w = 1'b1;

      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req", ifa.imem_req, 32'd0);
      chk("rst_valid", ifa.instr_valid, 32'd0);
      chk("rst_instr", ifa.instr, NOP_INSTR);
      chk("rst_pc_out", ifa.pc_out, 32'h0);
      chk("rst_halted", ifa.halted, 32'd0);
      chk("rst_fetch_err", ifa.fetch_err, 32'd0);
      chk("rst_instret", ifa.instret, 32'd0);
      chk("rst_w_pc_out", ifw.pc_out, 32'hFFFF_FFFC);

      // Straight-line run ending in halt (redirect on the same cycle loses).
      exp_a.push_back(32'h0); exp_a.push_back(32'h4); exp_a.push_back(32'h8);
      @(posedge clk); #1;
      rst_a = 1'b0;
      hs(32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 0);
      hs(32'h4, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 0);
      hs(32'h8, 32'h0000_005D, 1'b1, 1'b1, 32'h40, 0);
      chk("halt_halted", ifa.halted, 32'd1);
      chk("halt_instret", ifa.instret, 32'd2);
      chk("halt_valid", ifa.instr_valid, 32'd0);
      chk("halt_pc_out", ifa.pc_out, 32'h8);
      repeat (5) begin
         @(negedge clk);
         chk("halted_no_req", ifa.imem_req, 32'd0);
      end

      // Reset out of HALTED.
      @(posedge clk); #1;
      rst_a = 1'b1;
      @(negedge clk);
      chk("rst_halted_req", ifa.imem_req, 32'd0);
      exp_a.push_back(32'h0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(negedge clk);
      chk("post_rst_req", ifa.imem_req, 32'd1);
      chk("post_rst_halted", ifa.halted, 32'd0);
      chk("post_rst_instret", ifa.instret, 32'd0);
      chk("post_rst_instr", ifa.instr, NOP_INSTR);

      // Redirects (low bits masked), then back-pressure.
      exp_a.push_back(32'h10); exp_a.push_back(32'h100); exp_a.push_back(32'h104);
      hs(32'h0, 32'h0050_0093, 1'b0, 1'b1, 32'h13, 0);
      hs(32'h10, 32'h0000_0463, 1'b0, 1'b1, 32'h102, 0);
      chk("redir_instret", ifa.instret, 32'd2);
      hs(32'h100, 32'h1234_5013, 1'b0, 1'b0, 32'h0, 5);
      mute_a = 1'b1;
      chk("stall_instret", ifa.instret, 32'd3);

      // Timeout on the fetch of 0x104: WAIT entered one cycle after this FETCH.
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tmo_err_early", ifa.fetch_err, 32'd0);
         chk("tmo_valid", ifa.instr_valid, 32'd0);
      end
      @(negedge clk);
      chk("tmo_err", ifa.fetch_err, 32'd1);
      chk("tmo_req", ifa.imem_req, 32'd0);
      spur_a = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("spur_valid", ifa.instr_valid, 32'd0);
         chk("spur_instr", ifa.instr, 32'h1234_5013);
         chk("spur_pc_out", ifa.pc_out, 32'h104);
         chk("spur_err", ifa.fetch_err, 32'd1);
      end
      spur_a = 1'b0;

      // Reset mid-WAIT with memory silent.
      @(posedge clk); #1;
      rst_a = 1'b1;
      exp_a.push_back(32'h0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(posedge clk); #1;
      rst_a = 1'b1;
      @(negedge clk);
      chk("rst_wait_req", ifa.imem_req, 32'd0);
      exp_a.push_back(32'h0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      mute_a = 1'b0;
      @(negedge clk);
      chk("post_wait_req", ifa.imem_req, 32'd1);
      chk("post_wait_err", ifa.fetch_err, 32'd0);
      chk("post_wait_pc", ifa.pc_out, 32'h0);
      chk("post_wait_instr", ifa.instr, NOP_INSTR);
      exp_a.push_back(32'h4);
      hs(32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 0);

      // PC wrap on the second instance.
      exp_w.push_back(32'hFFFF_FFFC); exp_w.push_back(32'h0);
      @(posedge clk); #1;
      rst_w = 1'b0;
      for (int k = 0; k < 2; k++) begin
         int n = 0;
         while (ifw.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("w_valid", ifw.instr_valid, 32'd1);
         if (k == 0) begin
            chk("w_pc_out", ifw.pc_out, 32'hFFFF_FFFC);
            chk("w_pc_plus4", ifw.pc_plus4, 32'h0);
            ifw.instr_ready = 1'b1;
            @(posedge clk); #1;
            ifw.instr_ready = 1'b0;
            chk("w_instret", ifw.instret, 32'd1);
         end else begin
            chk("w_pc_out_wrapped", ifw.pc_out, 32'h0);
            chk("w_pc_plus4_wrapped", ifw.pc_plus4, 32'h4);
         end
      end

      repeat (3) @(negedge clk);
      chk("a_queue_empty", exp_a.size(), 32'd0);
      chk("w_queue_empty", exp_w.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the instruction decoder/controller. It owns the PC and issues one request at a time to instruction memory. It holds each returned word as the current instruction (instr[6:0], instr[14:12] and instr[31:25] drive the decoder's opcode, funct3 and funct7). On the execute handshake it advances or redirects the PC, and it stops fetching on HALT.

Parameters:
XLEN, 32, data/address width.
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
TIMEOUT, 255, maximum cycles spent in WAIT before fetch_err; range 1..65535.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
imem_req  out  1  fetch request; high for exactly one cycle per fetch.
imem_addr  out  XLEN  word address of the request; equals pc.
imem_rvalid  in  1  response valid; earliest one cycle after imem_req.
imem_rdata  in  XLEN  instruction word, sampled when imem_rvalid=1 in WAIT.
instr  out  XLEN  current instruction to the decoder.
instr_valid  out  1  instr holds a fetched, not-yet-consumed instruction.
pc_out  out  XLEN  PC of instr.
pc_plus4  out  XLEN  pc_out+4 modulo 2^XLEN; used as the jal/jalr link value.
instr_ready  in  1  execute consumes instr this cycle.
halt  in  1  decoder hlt for the current instr.
redirect_valid  in  1  taken branch/jump for the current instr.
redirect_pc  in  XLEN  branch/jump target.
halted  out  1  sticky; core stopped.
fetch_err  out  1  sticky; memory timeout.
instret  out  32  retired-instruction count.

Behaviour:
- States: FETCH, WAIT, HOLD, HALTED. All state, pc, instr, counters are registers; imem_req/imem_addr/instr_valid decode from state.
- Reset:
  - state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, halted=0, fetch_err=0, instret=0, timeout count=0.
  - imem_req is 0 during the rst cycle.
  - The memory shares rst and drops outstanding requests, so rst in WAIT simply restarts at FETCH.
- FETCH: imem_req=1, imem_addr=pc, clear timeout count; next state WAIT.
- WAIT:
  - If imem_rvalid: instr<=imem_rdata and go to HOLD (instr_valid=1 from the next cycle).
  - Otherwise increment the count. When the count reaches TIMEOUT without rvalid, set fetch_err=1 and go to HALTED.
- imem_rvalid in any state other than WAIT is ignored.
- HOLD: instr_valid=1, and instr, pc_out and pc_plus4 are stable. The cycle with instr_ready=1 is the handshake. Priority on that cycle:
  - halt=1: go to HALTED, halted=1. instret is not incremented and the PC is not changed.
  - else redirect_valid=1: pc<=redirect_pc & ~3 (low 2 bits forced to 0), instret+=1, go to FETCH.
  - else: pc<=pc+4 (wraps 0xFFFF_FFFC→0), instret+=1, go to FETCH.
- halt and redirect_valid are ignored outside the HOLD handshake cycle.
- Minimum throughput is 3 cycles per instruction (FETCH, WAIT with immediate rvalid, HOLD with immediate ready).
- HALTED: imem_req=0, instr_valid=0, and all outputs are frozen except halted/fetch_err. Exit only by rst.
- instret wraps modulo 2^32.
- Simultaneous rst with any event: rst wins.

Decomposition:
- Shared package riscv_pkg holds:
  - the fetch state enum (FETCH, WAIT, HOLD, HALTED);
  - NOP_INSTR = 32'h0000_0013;
  - OPC_HALT = 7'd93;
  - XLEN.
- No sub-module; the timeout counter and PC incrementer are inline.

Test Plan:
- Reset then memory answering 1 cycle after each req, instr_ready=1, words 0x00500093, 0x00000013, halt on the 3rd word → imem_addr sequence 0x0, 0x4, 0x8; halted=1 after the 3rd handshake; instret=2; no imem_req afterwards.
- Redirect: redirect_valid=1, redirect_pc=0x0000_0102 on the handshake at pc=0x10 → next imem_addr=0x0000_0100; instret increments.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD → instr, pc_out and instr_valid stable; no imem_req; advance on the 6th cycle.
- Timeout: TIMEOUT=4, no rvalid → fetch_err=1 and halted state exactly 4 cycles after WAIT entry; spurious rvalid afterwards is ignored.
- Wrap: RESET_PC=0xFFFF_FFFC, one instruction retired → pc_plus4=0 and next imem_addr=0x0.
- Reset mid-WAIT and in HALTED → pc=RESET_PC, instr=NOP, flags cleared, imem_req=1 in the first cycle after rst deasserts.
